// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - byte push interface for the buffered UART transmitter
interface uart_tx_buffered_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready;
    logic       tx_buffer_empty;
    logic       overflow;

    modport master (
        output data_in,
        output data_valid,
        input  ready,
        input  tx_buffer_empty,
        input  overflow
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output ready,
        output tx_buffer_empty,
        output overflow
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - 8N1 UART transmitter with byte FIFO and cts flow control
module uart_tx_buffered #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                baud_clk,
    input  logic                cts,
    output logic                tx,
    output logic                busy,
    uart_tx_buffered_if.slave   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           ready_q;
    logic           empty_q;
    logic           overflow_q;
    logic [7:0]     shreg;
    logic [2:0]     bit_idx;
    logic           push;
    logic           pop;

    assign bus.ready           = ready_q;
    assign bus.tx_buffer_empty = empty_q;
    assign bus.overflow        = overflow_q;

    // A push is taken only against the registered ready; a frame may start only
    // from a line that is idle or finishing its stop bit, and only with cts high.
    assign push = bus.data_valid && ready_q;
    assign pop  = baud_clk && cts && !empty_q && ((state == IDLE) || (state == STOP));

    // Occupancy after this edge, used to register ready and empty flags.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Byte storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // FIFO pointers, occupancy and the status flags derived from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ready_q    <= 1'b1;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_next;
            ready_q    <= (count_next != FULL_CNT);
            empty_q    <= (count_next == '0);
            overflow_q <= bus.data_valid && !ready_q;
        end
    end

    // Frame sequencer: every line change happens on a baud_clk edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
        end else if (baud_clk) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_idx == 3'd7) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end else begin
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for uart_tx_buffered
module tb_uart_tx_buffered;

    localparam int DEPTH    = 4;
    localparam int BAUD_DIV = 6;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic baud_clk = 1'b0;
    logic cts      = 1'b0;
    logic tx;
    logic busy;

    uart_tx_buffered_if bus ();

    uart_tx_buffered #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_clk (baud_clk),
        .cts      (cts),
        .tx       (tx),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: bytes accepted but not started, bits still to send
    // for the frame on the line, and the line/busy level expected right now.
    logic [7:0] fifo_q[$];
    logic       bitq[$];
    logic       line_log[$];
    logic       exp_tx   = 1'b1;
    logic       exp_busy = 1'b0;
    int         ovf_seen = 0;
    int         m_pre;
    logic [7:0] m_b;
    logic       m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Baud enable: one clk wide every BAUD_DIV clocks, changed on the falling edge.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            baud_clk = (cnt == 0);
            cnt = (cnt + 1) % BAUD_DIV;
        end
    end

    // Monitor / model step, 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                fifo_q.delete();
                bitq.delete();
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
                chk("rst_tx", tx, 1);
                chk("rst_busy", busy, 0);
                chk("rst_ready", bus.ready, 1);
                chk("rst_empty", bus.tx_buffer_empty, 1);
                chk("rst_overflow", bus.overflow, 0);
            end else begin
                m_pre = fifo_q.size();
                if (baud_clk) begin
                    if (bitq.size() > 0) begin
                        exp_tx   = bitq.pop_front();
                        exp_busy = 1'b1;
                    end else if (m_pre > 0 && cts) begin
                        m_b = fifo_q.pop_front();
                        bitq.push_back(1'b0);
                        for (int i = 0; i < 8; i++) bitq.push_back(m_b[i]);
                        bitq.push_back(1'b1);
                        exp_tx   = bitq.pop_front();
                        exp_busy = 1'b1;
                    end else begin
                        exp_tx   = 1'b1;
                        exp_busy = 1'b0;
                    end
                    line_log.push_back(tx);
                end
                m_ovf = 1'b0;
                if (bus.data_valid) begin
                    if (m_pre < DEPTH) fifo_q.push_back(bus.data_in);
                    else m_ovf = 1'b1;
                end
                chk("tx", tx, exp_tx);
                chk("busy", busy, exp_busy);
                chk("ready", bus.ready, (fifo_q.size() < DEPTH));
                chk("empty", bus.tx_buffer_empty, (fifo_q.size() == 0));
                chk("overflow", bus.overflow, m_ovf);
                if (bus.overflow) ovf_seen++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Caller is positioned at a step point; the byte is presented for one edge.
    task automatic push1(input logic [7:0] b);
        bus.data_valid = 1'b1;
        bus.data_in    = b;
        step();
        bus.data_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_busy) && n < max) begin
            step();
            n++;
        end
        step();
        chk(name, (n < max), 1);
    endtask

    task automatic wait_bits_left(input string name, input int left, input int max);
        int n;
        n = 0;
        while (!(exp_busy && bitq.size() == left) && n < max) begin
            step();
            n++;
        end
        chk(name, (n < max), 1);
    endtask

    // Finds the first start bit in the line log and checks len bits (MSB of pat
    // first) followed by an idle high period.
    task automatic check_log(input string name, input logic [31:0] pat, input int len);
        int   k;
        logic v;
        k = -1;
        for (int i = 0; i < line_log.size(); i++) begin
            if (line_log[i] == 1'b0) begin
                k = i;
                break;
            end
        end
        chk({name, "_start"}, (k >= 0), 1);
        if (k >= 0) begin
            for (int i = 0; i < len; i++) begin
                v = (k + i < line_log.size()) ? line_log[k + i] : 1'bx;
                chk(name, v, pat[len - 1 - i]);
            end
            v = (k + len < line_log.size()) ? line_log[k + len] : 1'bx;
            chk({name, "_idle_after"}, v, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ovf0;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        cts            = 1'b0;
        rst_n          = 1'b0;
        repeat (3) step();
        chk("reset_tx", tx, 1);
        chk("reset_empty", bus.tx_buffer_empty, 1);
        rst_n = 1'b1;
        repeat (2 * BAUD_DIV) step();

        // Single byte 0xA5.
        cts = 1'b1;
        line_log.delete();
        push1(8'hA5);
        wait_drain("a5_drain", 40 * BAUD_DIV);
        check_log("a5_bits", 32'b0101001011, 10);

        // 0x00 then 0xFF back to back, no idle period between frames.
        line_log.delete();
        push1(8'h00);
        push1(8'hFF);
        wait_drain("b2b_drain", 60 * BAUD_DIV);
        check_log("b2b_bits", 32'b0000_0000_0101_1111_1111, 20);

        // Held by cts: fill, overflow once, then release in order.
        cts  = 1'b0;
        ovf0 = ovf_seen;
        line_log.delete();
        push1(8'h11);
        push1(8'h22);
        push1(8'h33);
        push1(8'h44);
        push1(8'h55);
        step();
        chk("full_ready", bus.ready, 0);
        chk("full_ovf_count", ovf_seen - ovf0, 1);
        chk("full_tx_idle", tx, 1);
        cts = 1'b1;
        wait_drain("full_drain", 80 * BAUD_DIV);
        chk("full_empty_after", bus.tx_buffer_empty, 1);

        // cts dropped mid-frame: frame completes, next frame waits for cts.
        push1(8'h3C);
        push1(8'hC3);
        wait_bits_left("cts_bit3", 5, 20 * BAUD_DIV);
        cts = 1'b0;
        n = 0;
        while (exp_busy && n < 20 * BAUD_DIV) begin
            step();
            n++;
        end
        repeat (4 * BAUD_DIV) step();
        chk("cts_hold_tx", tx, 1);
        chk("cts_hold_busy", busy, 0);
        chk("cts_hold_empty", bus.tx_buffer_empty, 0);
        cts = 1'b1;
        n = 0;
        while (tx == 1'b1 && n < 3 * BAUD_DIV) begin
            step();
            n++;
        end
        chk("cts_resume_latency_ok", (n <= BAUD_DIV), 1);
        wait_drain("cts_drain", 40 * BAUD_DIV);

        // Reset during bit5 with two bytes still queued.
        push1(8'h96);
        push1(8'h69);
        push1(8'hF0);
        wait_bits_left("rst_bit5", 3, 20 * BAUD_DIV);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_empty", bus.tx_buffer_empty, 1);
        chk("midrst_ready", bus.ready, 1);
        repeat (3) step();
        rst_n = 1'b1;
        line_log.delete();
        repeat (15 * BAUD_DIV) step();
        n = 0;
        for (int i = 0; i < line_log.size(); i++) if (line_log[i] == 1'b0) n++;
        chk("midrst_no_frames", n, 0);

        // Push on the same edge as a baud pulse in IDLE.
        n = 0;
        while (!baud_clk && n < 2 * BAUD_DIV) begin
            step();
            n++;
        end
        push1(8'h81);
        chk("align_no_start", tx, 1);
        n = 0;
        while (tx == 1'b1 && n < 3 * BAUD_DIV) begin
            step();
            n++;
        end
        chk("align_start_delay", n, BAUD_DIV);
        wait_drain("align_drain", 40 * BAUD_DIV);

        // Random traffic with cts toggling; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            bus.data_valid = ($urandom_range(0, 3) == 0);
            bus.data_in    = 8'($urandom);
            if ($urandom_range(0, 99) == 0) cts = ~cts;
            step();
        end
        bus.data_valid = 1'b0;
        cts = 1'b1;
        wait_drain("rand_drain", 100 * BAUD_DIV);
        chk("rand_empty_after", bus.tx_buffer_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, number of buffered bytes (power of two, 2..16).
REQ-002 SHALL provide port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port baud_clk  input  1  one-clk-wide bit-rate enable pulse, synchronous to clk.
REQ-005 SHALL provide port data_in  input  8  byte to transmit.
REQ-006 SHALL provide port data_valid  input  1  push request for data_in.
REQ-007 SHALL provide port ready  output  1  high when the FIFO can accept a byte (not full).
REQ-008 SHALL provide port cts  input  1  peer permits transmission (active high).
REQ-009 SHALL provide port tx  output  1  serial line, idle high.
REQ-010 SHALL provide port busy  output  1  high while a frame is on the line.
REQ-011 SHALL provide port tx_buffer_empty  output  1  high when the FIFO holds no bytes.
REQ-012 SHALL provide port overflow  output  1  one-clk pulse when a push is dropped.

Function
REQ-013 Frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1.
REQ-014 Each bit SHALL last exactly one baud_clk period; tx SHALL change only on clk edges where baud_clk=1.
REQ-015 Push SHALL occur on a clk edge with data_valid=1 and ready=1; ready SHALL equal !full, registered, with occupancy count width clog2(FIFO_DEPTH)+1.
REQ-016 data_valid=1 while ready=0 SHALL drop the byte, leave the FIFO unchanged, and pulse overflow for one clk, including when a pop occurs in the same cycle.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP; busy=1 in every state except IDLE.
REQ-018 IDLE: on baud_clk with FIFO non-empty and cts=1, the FSM SHALL pop the head into a shift register, drive tx=0, and enter START.
REQ-019 START: on baud_clk the FSM SHALL drive bit0 and enter DATA with bit index 0.
REQ-020 DATA: on each baud_clk the FSM SHALL drive the next bit; after bit7 has occupied one period it SHALL drive tx=1 and enter STOP.
REQ-021 STOP: on baud_clk, if the FIFO is non-empty and cts=1, the FSM SHALL pop and enter START with tx=0, giving back-to-back frames with no idle gap; otherwise it SHALL enter IDLE with tx=1.
REQ-022 cts SHALL be sampled only at frame start (REQ-018, REQ-021); deassertion mid-frame SHALL NOT abort the frame.
REQ-023 A byte pushed on the same clk edge as a baud_clk pulse in IDLE SHALL NOT start until the next baud_clk pulse.
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop on a non-full FIFO SHALL keep occupancy unchanged.
REQ-025 tx_buffer_empty SHALL be high exactly when occupancy=0; it SHALL be independent of busy.

Reset
REQ-026 rst_n=0 SHALL immediately force tx=1, ready=1, busy=0, tx_buffer_empty=1, overflow=0, state=IDLE, occupancy=0, pointers=0.
REQ-027 Reset mid-frame SHALL abandon the frame and discard all buffered bytes; after release, tx SHALL stay 1 until a new byte is pushed and started.

Verification
REQ-028 Push 0xA5 with cts=1 -> tx over successive baud periods: 0,1,0,1,0,0,1,0,1,1; busy high for 10 periods, then tx=1.
REQ-029 Push 0x00 then 0xFF -> 20 contiguous bit periods (0 x9, 1, 0, 1 x9), no idle period between frames.
REQ-030 cts=0, push 5 bytes with FIFO_DEPTH=4 -> ready=0 after the 4th, overflow pulses once on the 5th, tx stays 1; raise cts -> exactly 4 frames in push order, then tx_buffer_empty=1.
REQ-031 Push 2 bytes, drop cts during bit3 of frame 1 -> frame 1 completes with stop bit, frame 2 is not started, tx=1; raise cts -> frame 2 starts at the next baud_clk.
REQ-032 Assert rst_n=0 during bit5 of a frame with 2 bytes queued -> tx=1 in the same cycle, tx_buffer_empty=1, busy=0; no further frames follow after release.
REQ-033 Push on the same edge as a baud_clk pulse in IDLE -> start bit begins at the following baud_clk pulse, not the current one.
